// File: rtl/mor1kx_spr_master_pkg.sv
// rtl/mor1kx_spr_master_pkg.sv - SPR group numbering, address field helpers and FSM encodings
package mor1kx_spr_master_pkg;

    localparam logic [4:0] SPR_GROUP_SYS   = 5'd0;
    localparam logic [4:0] SPR_GROUP_DMMU  = 5'd1;
    localparam logic [4:0] SPR_GROUP_IMMU  = 5'd2;
    localparam logic [4:0] SPR_GROUP_DC    = 5'd3;
    localparam logic [4:0] SPR_GROUP_IC    = 5'd4;
    localparam logic [4:0] SPR_GROUP_MAC   = 5'd5;
    localparam logic [4:0] SPR_GROUP_DU    = 5'd6;
    localparam logic [4:0] SPR_GROUP_PCU   = 5'd7;
    localparam logic [4:0] SPR_GROUP_PM    = 5'd8;
    localparam logic [4:0] SPR_GROUP_PIC   = 5'd9;
    localparam logic [4:0] SPR_GROUP_TT    = 5'd10;
    localparam logic [4:0] SPR_GROUP_FPU   = 5'd11;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    function automatic logic [4:0] spr_group(input logic [15:0] addr);
        return addr[15:11];
    endfunction

    function automatic logic [10:0] spr_offset(input logic [15:0] addr);
        return addr[10:0];
    endfunction

endpackage

// File: rtl/mor1kx_spr_rdata_mux.sv
// rtl/mor1kx_spr_rdata_mux.sv - selects one group's 32-bit read data from the flattened bus
module mor1kx_spr_rdata_mux (
    input  logic [1023:0] bus_dat,
    input  logic [4:0]    sel,
    output logic [31:0]   rdata
);

    logic [9:0] base;

    assign base  = {sel, 5'd0};
    assign rdata = bus_dat[base +: 32];

endmodule

// File: rtl/mor1kx_spr_master.sv
// rtl/mor1kx_spr_master.sv - SPR bus initiator: one request in, one group access, one response out
module mor1kx_spr_master
    import mor1kx_spr_master_pkg::*;
#(
    parameter logic [31:0] GROUP_PRESENT  = 32'h0000_00FF,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  logic          req_we_i,
    input  logic [15:0]   req_addr_i,
    input  logic [31:0]   req_wdata_i,
    input  logic          req_sys_mode_i,
    output logic          resp_valid_o,
    input  logic          resp_ready_i,
    output logic [31:0]   resp_rdata_o,
    output logic          resp_err_o,
    output logic [31:0]   spr_access_o,
    output logic          spr_we_o,
    output logic          spr_re_o,
    output logic [15:0]   spr_addr_o,
    output logic [31:0]   spr_dat_o,
    output logic          spr_sys_mode_o,
    input  logic [31:0]   spr_bus_ack_i,
    input  logic [1023:0] spr_bus_dat_i
);

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [1:0]  state;
    logic        we_q;
    logic [15:0] addr_q;
    logic [31:0] wdata_q;
    logic        sys_mode_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic [7:0]  cnt;

    logic [4:0]  grp;
    logic [4:0]  req_grp;
    logic        grp_ack;
    logic        in_access;
    logic [31:0] mux_rdata;

    assign grp       = spr_group(addr_q);
    assign req_grp   = spr_group(req_addr_i);
    assign grp_ack   = spr_bus_ack_i[grp];
    assign in_access = (state == ST_ACCESS);

    mor1kx_spr_rdata_mux u_rdata_mux (
        .bus_dat (spr_bus_dat_i),
        .sel     (grp),
        .rdata   (mux_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            we_q       <= 1'b0;
            addr_q     <= 16'd0;
            wdata_q    <= 32'd0;
            sys_mode_q <= 1'b0;
            rdata_q    <= 32'd0;
            err_q      <= 1'b0;
            cnt        <= 8'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        we_q       <= req_we_i;
                        addr_q     <= req_addr_i;
                        wdata_q    <= req_wdata_i;
                        sys_mode_q <= req_sys_mode_i;
                        // Absent groups never touch the bus; they answer with an error directly.
                        if (GROUP_PRESENT[req_grp]) begin
                            state <= ST_ACCESS;
                            cnt   <= 8'd0;
                        end else begin
                            state   <= ST_RESP;
                            err_q   <= 1'b1;
                            rdata_q <= 32'd0;
                        end
                    end
                end
                ST_ACCESS: begin
                    // An ack arriving on the final allowed cycle still beats the timeout.
                    if (grp_ack) begin
                        rdata_q <= we_q ? 32'd0 : mux_rdata;
                        err_q   <= 1'b0;
                        state   <= ST_RESP;
                    end else if (cnt == TIMEOUT_LAST) begin
                        rdata_q <= 32'd0;
                        err_q   <= 1'b1;
                        state   <= ST_RESP;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                ST_RESP: begin
                    if (resp_ready_i) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign req_ready_o    = (state == ST_IDLE);
    assign resp_valid_o   = (state == ST_RESP);
    assign resp_rdata_o   = resp_valid_o ? rdata_q : 32'd0;
    assign resp_err_o     = resp_valid_o & err_q;
    assign spr_access_o   = in_access ? (32'd1 << grp) : 32'd0;
    assign spr_we_o       = in_access & we_q;
    assign spr_re_o       = in_access & ~we_q;
    assign spr_addr_o     = in_access ? addr_q : 16'd0;
    assign spr_dat_o      = in_access ? wdata_q : 32'd0;
    assign spr_sys_mode_o = sys_mode_q;

endmodule

// File: tb/tb_mor1kx_spr_master.sv
// tb/tb_mor1kx_spr_master.sv - directed self-checking bench for mor1kx_spr_master
module tb_mor1kx_spr_master;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [15:0]   req_addr;
    logic [31:0]   req_wdata;
    logic          req_sys_mode;
    logic          resp_valid;
    logic          resp_ready;
    logic [31:0]   resp_rdata;
    logic          resp_err;
    logic [31:0]   spr_access;
    logic          spr_we;
    logic          spr_re;
    logic [15:0]   spr_addr;
    logic [31:0]   spr_dat;
    logic          spr_sys_mode;
    logic [31:0]   bus_ack;
    logic [1023:0] bus_dat;

    logic [31:0]   ack_mask;
    logic [31:0]   stray_ack;

    int errors = 0;
    int checks = 0;
    int n_strobe;

    always #5 clk = ~clk;

    // Combinational responder: acks the strobed group when enabled, plus optional stray acks.
    assign bus_ack = (spr_access & ack_mask) | stray_ack;

    mor1kx_spr_master dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_we_i       (req_we),
        .req_addr_i     (req_addr),
        .req_wdata_i    (req_wdata),
        .req_sys_mode_i (req_sys_mode),
        .resp_valid_o   (resp_valid),
        .resp_ready_i   (resp_ready),
        .resp_rdata_o   (resp_rdata),
        .resp_err_o     (resp_err),
        .spr_access_o   (spr_access),
        .spr_we_o       (spr_we),
        .spr_re_o       (spr_re),
        .spr_addr_o     (spr_addr),
        .spr_dat_o      (spr_dat),
        .spr_sys_mode_o (spr_sys_mode),
        .spr_bus_ack_i  (bus_ack),
        .spr_bus_dat_i  (bus_dat)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic we, input logic [15:0] addr, input logic [31:0] wdata, input logic sys);
        req_valid    = 1'b1;
        req_we       = we;
        req_addr     = addr;
        req_wdata    = wdata;
        req_sys_mode = sys;
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 16'd0; req_wdata = 32'd0;
        req_sys_mode = 1'b0; resp_ready = 1'b1; bus_dat = '0; ack_mask = 32'd0; stray_ack = 32'd0;
        bus_dat[7*32 +: 32] = 32'h0000_002A;
        bus_dat[9*32 +: 32] = 32'hDEAD_BEEF;
        tick(); tick();
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_access", spr_access, 32'd0);
        check("rst_strobes", {30'd0, spr_we, spr_re}, 32'd0);
        check("rst_addr", {16'd0, spr_addr}, 32'd0);
        rst = 1'b0;
        tick();

        // Read PCCR0, combinational ack
        ack_mask = 32'hFFFF_FFFF;
        issue(1'b0, 16'h3800, 32'd0, 1'b0);
        check("rd_accept_ready", {31'd0, req_ready}, 32'd1);
        tick(); req_valid = 1'b0;
        check("rd_access", spr_access, 32'h0000_0080);
        check("rd_re", {30'd0, spr_we, spr_re}, 32'd1);
        check("rd_addr", {16'd0, spr_addr}, 32'h3800);
        check("rd_no_resp_c1", {31'd0, resp_valid}, 32'd0);
        tick();
        check("rd_access_c2", spr_access, 32'd0);
        check("rd_resp_valid", {31'd0, resp_valid}, 32'd1);
        check("rd_rdata", resp_rdata, 32'h0000_002A);
        check("rd_err", {31'd0, resp_err}, 32'd0);
        tick();
        check("rd_back_idle", {30'd0, req_ready, resp_valid}, 32'd2);

        // Write PCMR1 in supervisor mode
        issue(1'b1, 16'h3809, 32'h0000_0C01, 1'b1);
        tick(); req_valid = 1'b0;
        check("wr_access", spr_access, 32'h0000_0080);
        check("wr_strobes", {30'd0, spr_we, spr_re}, 32'd2);
        check("wr_dat", spr_dat, 32'h0000_0C01);
        check("wr_sys_mode", {31'd0, spr_sys_mode}, 32'd1);
        check("wr_addr", {16'd0, spr_addr}, 32'h3809);
        tick();
        check("wr_resp_valid", {31'd0, resp_valid}, 32'd1);
        check("wr_rdata", resp_rdata, 32'd0);
        check("wr_err", {31'd0, resp_err}, 32'd0);
        tick();

        // Absent group 20
        issue(1'b0, 16'hA000, 32'd0, 1'b0);
        tick(); req_valid = 1'b0;
        check("abs_access", spr_access, 32'd0);
        check("abs_resp_valid", {31'd0, resp_valid}, 32'd1);
        check("abs_err", {31'd0, resp_err}, 32'd1);
        check("abs_rdata", resp_rdata, 32'd0);
        tick();

        // Timeout: group 7 never acks
        ack_mask = 32'd0;
        n_strobe = 0;
        issue(1'b0, 16'h3800, 32'd0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            tick(); req_valid = 1'b0;
            if (spr_access == 32'h0000_0080) n_strobe++;
            if (resp_valid) break;
        end
        check("to_resp_valid", {31'd0, resp_valid}, 32'd1);
        check("to_strobe_cycles", n_strobe, 32'd16);
        check("to_err", {31'd0, resp_err}, 32'd1);
        check("to_rdata", resp_rdata, 32'd0);
        tick();

        // Ack on the 16th access cycle wins over timeout
        bus_dat[7*32 +: 32] = 32'h5555_AAAA;
        issue(1'b0, 16'h3800, 32'd0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            tick(); req_valid = 1'b0;
        end
        check("ack16_access", spr_access, 32'h0000_0080);
        ack_mask = 32'hFFFF_FFFF;
        tick();
        check("ack16_resp_valid", {31'd0, resp_valid}, 32'd1);
        check("ack16_err", {31'd0, resp_err}, 32'd0);
        check("ack16_rdata", resp_rdata, 32'h5555_AAAA);
        tick();

        // Back-pressure on the response
        bus_dat[7*32 +: 32] = 32'h1234_5678;
        resp_ready = 1'b0;
        issue(1'b0, 16'h3800, 32'd0, 1'b0);
        tick(); req_valid = 1'b0;
        tick();
        issue(1'b1, 16'h3809, 32'h0000_0777, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check("bp_resp_valid", {31'd0, resp_valid}, 32'd1);
            check("bp_rdata", resp_rdata, 32'h1234_5678);
            check("bp_req_ready", {31'd0, req_ready}, 32'd0);
            check("bp_access", spr_access, 32'd0);
            tick();
        end
        resp_ready = 1'b1;
        tick();
        check("bp_release_idle", {30'd0, req_ready, resp_valid}, 32'd2);
        tick(); req_valid = 1'b0;
        check("bp_next_access", spr_access, 32'h0000_0080);
        check("bp_next_we", {30'd0, spr_we, spr_re}, 32'd2);
        check("bp_next_dat", spr_dat, 32'h0000_0777);
        tick();
        check("bp_next_resp", {31'd0, resp_valid}, 32'd1);
        tick();

        // Stray ack on group 9 ignored, then reset on 3rd access cycle
        ack_mask = 32'd0;
        stray_ack = 32'h0000_0200;
        issue(1'b0, 16'h3800, 32'd0, 1'b0);
        tick(); req_valid = 1'b0;
        check("stray_access", spr_access, 32'h0000_0080);
        tick();
        check("stray_ignored", {31'd0, resp_valid}, 32'd0);
        check("stray_still_access", spr_access, 32'h0000_0080);
        tick();
        check("rst3_access", spr_access, 32'h0000_0080);
        rst = 1'b1;
        tick();
        rst = 1'b0; stray_ack = 32'd0;
        check("rst3_access_drop", spr_access, 32'd0);
        check("rst3_req_ready", {31'd0, req_ready}, 32'd1);
        n_strobe = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (resp_valid) n_strobe++;
        end
        check("rst3_no_resp", n_strobe, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mor1kx_spr_master.md
Name: mor1kx_spr_master

Overview:
- SPR bus initiator. Turns single-request transactions (mtspr/mfspr from the control path or the debug unit) into SPR bus accesses toward the group-decoded responder units: PCU, PIC, tick timer, caches, MMUs, debug.
- Decodes the SPR group, asserts that group's access strobe and waits for that group's bus ack.
- Captures read data and returns one response per request, with error reporting for absent groups and ack timeouts.
- Sits between the ctrl stage / debug port and all SPR-bearing units.

Parameters:
- GROUP_PRESENT, 32'h0000_00FF: bit g set = a responder exists for SPR group g.
- TIMEOUT_CYCLES, 16: ACCESS cycles allowed without ack before error; legal range 1..255.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when valid&ready
- req_we_i  in  1  1=write (mtspr), 0=read (mfspr)
- req_addr_i  in  16  SPR address; group = addr[15:11]
- req_wdata_i  in  32  write data
- req_sys_mode_i  in  1  requester is in supervisor mode
- resp_valid_o  out  1  response valid
- resp_ready_i  in  1  response consumed when valid&ready
- resp_rdata_o  out  32  read data; 0 for writes or errors
- resp_err_o  out  1  absent group or timeout
- spr_access_o  out  32  one-hot per-group access strobe
- spr_we_o  out  1  write strobe
- spr_re_o  out  1  read strobe
- spr_addr_o  out  16  address
- spr_dat_o  out  32  write data
- spr_sys_mode_o  out  1  registered requester mode
- spr_bus_ack_i  in  32  per-group ack
- spr_bus_dat_i  in  1024  per-group read data; group g occupies bits [32g+31:32g]

Behaviour:
- Clock `clk` and reset `rst`. Reset is synchronous and active-high; the block has one clock.
- FSM states: IDLE, ACCESS, RESP.

IDLE
- req_ready_o=1.
- On valid&ready, register we, addr, wdata and sys_mode.
- If GROUP_PRESENT[group]=1: go to ACCESS and clear the timeout counter.
- Otherwise: go to RESP with err=1, rdata=0, and drive no bus access.

ACCESS
- spr_access_o[group]=1; all other strobe bits are 0.
- spr_we_o=we and spr_re_o=~we.
- spr_addr_o, spr_dat_o and spr_sys_mode_o are held stable.
- If spr_bus_ack_i[group]=1 in a cycle:
  - latch rdata = we ? 0 : spr_bus_dat_i[group slice];
  - set err=0;
  - go to RESP.
- Acks on other groups are ignored.
- Otherwise increment the counter. When counter == TIMEOUT_CYCLES-1 and there is no ack: go to RESP with err=1, rdata=0.
- Ack in the same cycle as the timeout: ack wins (err=0).

RESP
- resp_valid_o=1. rdata and err are held stable until resp_ready_i=1; then go to IDLE.
- spr_access_o=0 and strobes are 0.
- req_ready_o=0 in ACCESS and RESP. One transaction is outstanding at a time; requests are not buffered.

Latency and strobes
- A combinational-ack responder gives: accept at cycle 0, access at cycle 1, resp_valid at cycle 2.
- An absent group gives resp_valid at cycle 1.
- spr_addr_o, spr_dat_o, spr_we_o and spr_re_o drive 0 outside ACCESS. All strobes are registered from the state.

Reset
- All outputs 0 except req_ready_o=1 (IDLE).
- Reset during ACCESS or RESP drops the access strobe the next cycle. The pending response is discarded; no resp_valid is issued.

Counter
- Width 8 bits.
- Cleared on entry to ACCESS.
- Never wraps, because the timeout fires first.

Decomposition:
- Shared defines header: SPR group field macro (addr[15:11]); group numbers (PCU group 7, PIC 9, tick timer 10, etc.); SPR_OFFSET macro; FSM state encodings.
- One natural sub-module, mor1kx_spr_rdata_mux: selects a 32-bit slice from the flattened 1024-bit input by 5-bit group.
- Everything else stays in the top.

Test Plan:
- Read PCCR0 (addr 16'h3800, group 7 present); responder acks combinationally with 32'h0000_002A -> spr_access_o=32'h80 for exactly 1 cycle, spr_re_o=1, resp_valid at cycle 2 with rdata=32'h2A, err=0.
- Write PCMR1 (16'h3809, wdata 32'h0000_0C01, sys_mode=1) -> spr_we_o=1, spr_dat_o=32'hC01, spr_sys_mode_o=1 during access; response rdata=0, err=0.
- Access group 20 (addr 16'hA000) with GROUP_PRESENT=32'hFF -> spr_access_o stays 0, resp_valid at cycle 1 with err=1, rdata=0.
- Group 7 never acks, TIMEOUT_CYCLES=16 -> strobe high exactly 16 cycles, then err=1. Variant with ack on the 16th cycle -> err=0 and data captured.
- Back-pressure: hold resp_ready_i=0 for 5 cycles -> resp_valid and rdata stable, req_ready_o=0, a new req_valid_i is not accepted. Release -> IDLE next cycle, next request accepted.
- Assert rst on the 3rd ACCESS cycle -> next cycle spr_access_o=0, req_ready_o=1, and no resp_valid afterward. Also check that a stray spr_bus_ack_i[9]=1 during a group-7 access is ignored.
